// File: rtl/amba3_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : amba3_axi_sram_slave
// Purpose  : AXI3 slave backed by an on-chip word memory. The write path
//            (AW -> W -> B) and the read path (AR -> R) are independent, and
//            each path holds at most one outstanding burst.
// Ports    : aclk/areset              clock, asynchronous active-high reset
//            aw* / awvalid / awready  write address channel
//            w*  / wvalid  / wready   write data channel
//            bid, bresp / bvalid / bready   write response channel
//            ar* / arvalid / arready  read address channel
//            rid, rdata, rresp, rlast / rvalid / rready   read data channel
// Options  : AMBA3_AXI_SLAVE_EXCL_EN adds a single-entry exclusive monitor.
//            When the macro is not defined, EXCLUSIVE and LOCKED accesses are
//            handled as NORMAL accesses.
// Revision : 1.0  initial release
// ============================================================================
module amba3_axi_sram_slave #(
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [TXID_SIZE-1:0]   awid,
  input  logic [ADDR_SIZE-1:0]   awaddr,
  input  logic [3:0]             awlen,
  input  logic [2:0]             awsize,
  input  logic [1:0]             awburst,
  input  logic [1:0]             awlock,
  input  logic [3:0]             awcache,
  input  logic [2:0]             awprot,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [TXID_SIZE-1:0]   wid,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wstrb,
  input  logic                   wlast,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [TXID_SIZE-1:0]   bid,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [TXID_SIZE-1:0]   arid,
  input  logic [ADDR_SIZE-1:0]   araddr,
  input  logic [3:0]             arlen,
  input  logic [2:0]             arsize,
  input  logic [1:0]             arburst,
  input  logic [1:0]             arlock,
  input  logic [3:0]             arcache,
  input  logic [2:0]             arprot,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [TXID_SIZE-1:0]   rid,
  output logic [DATA_SIZE-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rlast,
  output logic                   rvalid,
  input  logic                   rready
);
  localparam int STRB_SIZE = DATA_SIZE / 8;
  localparam int STRB_LG   = $clog2(STRB_SIZE);
  localparam int MEM_LG    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] SPAN = (ADDR_SIZE+1)'(MEM_DEPTH) << STRB_LG;

  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00, BURST_WRAP = 2'b10;
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  // Attributes that do not affect a memory responder.
  logic unused_attrs;
  assign unused_attrs = ^{awcache, awprot, arcache, arprot, awlock, arlock};

  function automatic logic [MEM_LG-1:0] widx(input logic [ADDR_SIZE-1:0] a);
    return a[STRB_LG +: MEM_LG];
  endfunction

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  // Response codes are numbered in priority order, so the sticky merge is a max.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Address of the beat following `a`; INCR carries are dropped at the top.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a,
      input logic [2:0] size, input logic [3:0] len, input logic [1:0] burst);
    logic [ADDR_SIZE-1:0] incr, aligned, mask;
    incr    = ADDR_SIZE'(1) << size;
    aligned = a & ~(incr - ADDR_SIZE'(1));
    mask    = ((ADDR_SIZE'(len) + ADDR_SIZE'(1)) << size) - ADDR_SIZE'(1);
    if (burst == BURST_FIXED)     return a;
    else if (burst == BURST_WRAP) return (a & ~mask) | ((aligned + incr) & mask);
    else                          return aligned + incr;
  endfunction

  // Write path state
  logic [1:0]           w_state_q, w_state_d;
  logic                 awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [TXID_SIZE-1:0] bid_q, bid_d;
  logic [ADDR_SIZE-1:0] aw_addr_q, aw_addr_d;
  logic [3:0]           aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]           aw_size_q, aw_size_d;
  logic [1:0]           aw_burst_q, aw_burst_d;
  logic                 w_block_q, w_block_d;   // whole burst must not reach memory
  logic                 beat_err, beat_last, mem_we;
  logic [MEM_LG-1:0]    mem_widx;
  // Read path state
  logic [0:0]           r_state_q, r_state_d;
  logic                 arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [TXID_SIZE-1:0] rid_q, rid_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic [ADDR_SIZE-1:0] ar_addr_q, ar_addr_d, rd_addr;
  logic [3:0]           ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]           ar_size_q, ar_size_d;
  logic [1:0]           ar_burst_q, ar_burst_d;
  logic                 rd_load;
`ifdef AMBA3_AXI_SLAVE_EXCL_EN
  logic                 mon_valid_q, mon_valid_d, aw_excl_hit, ar_excl_load;
  logic [TXID_SIZE-1:0] mon_id_q, mon_id_d;
  logic [MEM_LG-1:0]    mon_word_q, mon_word_d;
`endif

  always_comb begin
    w_state_d = w_state_q;  awready_d = awready_q; wready_d  = wready_q;
    bvalid_d  = bvalid_q;   bresp_d   = bresp_q;   bid_d     = bid_q;
    aw_addr_d = aw_addr_q;  aw_len_d  = aw_len_q;  aw_size_d = aw_size_q;
    aw_burst_d = aw_burst_q; w_cnt_d  = w_cnt_q;   w_block_d = w_block_q;
    beat_err  = 1'b0;       beat_last = 1'b0;      mem_we    = 1'b0;
    mem_widx  = widx(aw_addr_q);
`ifdef AMBA3_AXI_SLAVE_EXCL_EN
    aw_excl_hit = 1'b0;
`endif
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          awready_d = 1'b0;  wready_d = 1'b1;  w_state_d = W_DATA;
          bid_d = awid;  aw_addr_d = awaddr;  aw_len_d = awlen;
          aw_size_d = awsize;  aw_burst_d = awburst;  w_cnt_d = 4'd0;
          bresp_d = RESP_OKAY;  w_block_d = 1'b0;
          if ({1'b0, awaddr} >= SPAN) begin
            bresp_d = RESP_DECERR;  w_block_d = 1'b1;
          end else if (awsize > 3'(STRB_LG) ||
                       (awburst == BURST_WRAP && !wrap_len_ok(awlen))) begin
            bresp_d = RESP_SLVERR;  w_block_d = 1'b1;
          end
`ifdef AMBA3_AXI_SLAVE_EXCL_EN
          else if (awlock == 2'b01) begin
            // A failed exclusive write completes OKAY but never touches memory.
            if (mon_valid_q && mon_id_q == awid && mon_word_q == widx(awaddr)) begin
              bresp_d = RESP_EXOKAY;  aw_excl_hit = 1'b1;
            end else begin
              w_block_d = 1'b1;
            end
          end
`endif
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          beat_last = wlast || (w_cnt_q == aw_len_q);
          beat_err  = (wid != bid_q) || (wlast != (w_cnt_q == aw_len_q));
          mem_we    = !w_block_q && !beat_err;
          if (beat_err) bresp_d = resp_max(bresp_q, RESP_SLVERR);
          if (beat_last) begin
            wready_d = 1'b0;  bvalid_d = 1'b1;  w_state_d = W_RESP;
          end else begin
            w_cnt_d   = w_cnt_q + 4'd1;
            aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q);
          end
        end
      end
      W_RESP: begin
        if (bready && bvalid_q) begin
          bvalid_d = 1'b0;  awready_d = 1'b1;  w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;  arready_d = arready_q; rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;    rresp_d   = rresp_q;   rid_d     = rid_q;
    ar_addr_d = ar_addr_q;  ar_len_d  = ar_len_q;  ar_size_d = ar_size_q;
    ar_burst_d = ar_burst_q; r_cnt_d  = r_cnt_q;
    rd_addr   = ar_addr_q;  rd_load   = 1'b0;
`ifdef AMBA3_AXI_SLAVE_EXCL_EN
    ar_excl_load = 1'b0;
`endif
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          arready_d = 1'b0;  rvalid_d = 1'b1;  r_state_d = R_DATA;
          rid_d = arid;  ar_addr_d = araddr;  ar_len_d = arlen;
          ar_size_d = arsize;  ar_burst_d = arburst;  r_cnt_d = 4'd0;
          rlast_d = (arlen == 4'd0);  rd_addr = araddr;  rd_load = 1'b1;
          rresp_d = RESP_OKAY;
          if ({1'b0, araddr} >= SPAN)
            rresp_d = RESP_DECERR;
          else if (arsize > 3'(STRB_LG) ||
                   (arburst == BURST_WRAP && !wrap_len_ok(arlen)))
            rresp_d = RESP_SLVERR;
`ifdef AMBA3_AXI_SLAVE_EXCL_EN
          else if (arlock == 2'b01) begin
            rresp_d = RESP_EXOKAY;  ar_excl_load = 1'b1;
          end
`endif
        end
      end
      default: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;  rlast_d = 1'b0;  arready_d = 1'b1;  r_state_d = R_IDLE;
          end else begin
            // Prefetch the next beat so beats stream without a bubble.
            rd_addr   = next_addr(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q);
            ar_addr_d = rd_addr;  r_cnt_d = r_cnt_q + 4'd1;  rd_load = 1'b1;
            rlast_d   = (r_cnt_q + 4'd1 == ar_len_q);
          end
        end
      end
    endcase
    // Memory is sampled before this edge's write lands, so a colliding read sees old data.
    rdata_d = rdata_q;
    if (rd_load) rdata_d = rresp_d[1] ? '0 : mem[widx(rd_addr)];
  end

`ifdef AMBA3_AXI_SLAVE_EXCL_EN
  always_comb begin
    mon_valid_d = mon_valid_q;  mon_id_d = mon_id_q;  mon_word_d = mon_word_q;
    if (aw_excl_hit || (mem_we && mem_widx == mon_word_q)) mon_valid_d = 1'b0;
    if (ar_excl_load) begin
      mon_valid_d = 1'b1;  mon_id_d = arid;  mon_word_d = widx(araddr);
    end
  end
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_IDLE;  awready_q <= 1'b0;  wready_q <= 1'b0;  bvalid_q <= 1'b0;
      bresp_q <= RESP_OKAY;  bid_q <= '0;  aw_addr_q <= '0;  aw_len_q <= '0;
      aw_size_q <= '0;  aw_burst_q <= '0;  w_cnt_q <= '0;  w_block_q <= 1'b0;
      r_state_q <= R_IDLE;  arready_q <= 1'b0;  rvalid_q <= 1'b0;  rlast_q <= 1'b0;
      rresp_q <= RESP_OKAY;  rid_q <= '0;  rdata_q <= '0;  ar_addr_q <= '0;
      ar_len_q <= '0;  ar_size_q <= '0;  ar_burst_q <= '0;  r_cnt_q <= '0;
`ifdef AMBA3_AXI_SLAVE_EXCL_EN
      mon_valid_q <= 1'b0;  mon_id_q <= '0;  mon_word_q <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;  awready_q <= awready_d;  wready_q <= wready_d;
      bvalid_q <= bvalid_d;  bresp_q <= bresp_d;  bid_q <= bid_d;
      aw_addr_q <= aw_addr_d;  aw_len_q <= aw_len_d;  aw_size_q <= aw_size_d;
      aw_burst_q <= aw_burst_d;  w_cnt_q <= w_cnt_d;  w_block_q <= w_block_d;
      r_state_q <= r_state_d;  arready_q <= arready_d;  rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;  rresp_q <= rresp_d;  rid_q <= rid_d;  rdata_q <= rdata_d;
      ar_addr_q <= ar_addr_d;  ar_len_q <= ar_len_d;  ar_size_q <= ar_size_d;
      ar_burst_q <= ar_burst_d;  r_cnt_q <= r_cnt_d;
`ifdef AMBA3_AXI_SLAVE_EXCL_EN
      mon_valid_q <= mon_valid_d;  mon_id_q <= mon_id_d;  mon_word_q <= mon_word_d;
`endif
    end
  end

  // Storage is never reset; contents survive areset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_SIZE; b++)
        if (wstrb[b]) mem[mem_widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign awready = awready_q;  assign wready = wready_q;  assign bvalid = bvalid_q;
  assign bresp   = bresp_q;    assign bid    = bid_q;
  assign arready = arready_q;  assign rvalid = rvalid_q;  assign rlast  = rlast_q;
  assign rresp   = rresp_q;    assign rid    = rid_q;     assign rdata  = rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_amba3_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_amba3_axi_sram_slave
// Purpose  : Directed bench for amba3_axi_sram_slave. Stimulus tasks push the
//            expected B/R responses into queues; monitors pop and compare on
//            every response handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_amba3_axi_sram_slave;
  localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [1:0] NORMAL = 2'b00, EXCL = 2'b01;
`ifdef AMBA3_AXI_SLAVE_EXCL_EN
  localparam logic [1:0] EXP_EX = EXOKAY;
  localparam bit         EXCL_ON = 1'b1;
`else
  localparam logic [1:0] EXP_EX = OKAY;
  localparam bit         EXCL_ON = 1'b0;
`endif

  logic aclk = 1'b0, areset = 1'b1;
  logic [3:0] awid, wid, bid, arid, rid, awlen, arlen, awcache, arcache, wstrb;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, awlock, arlock, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  amba3_axi_sram_slave dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  int n_tests = 0, n_fail = 0;
  bit r_mon_en = 1'b1;
  logic [31:0] wbuf[16];
  logic [31:0] rexp[16];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitors: a response transfers at the posedge following a negedge with valid&ready.
  always @(negedge aclk) begin
    rexp_t re;
    bexp_t be;
    if (!areset && r_mon_en && rvalid && rready) begin
      if (rq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL r_unexpected: got beat %h, required none", {rid, rdata, rresp, rlast});
      end else begin
        re = rq.pop_front();
        check("r_beat{id,data,resp,last}", 64'({rid, rdata, rresp, rlast}), 64'(re));
      end
    end
    if (!areset && bvalid && bready) begin
      if (bq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: got %h, required none", {bid, bresp});
      end else begin
        be = bq.pop_front();
        check("b_resp{id,resp}", 64'({bid, bresp}), 64'(be));
      end
    end
  end

  function automatic logic rdy(input int ch);
    case (ch)
      0:       return awready;
      1:       return wready;
      default: return arready;
    endcase
  endfunction

  task automatic hs_wait(input int ch, input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge aclk);
      if (rdy(ch)) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL %s: got timeout, required handshake", nm); end
    @(posedge aclk); #1;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 100 && (rq.size() != 0 || bq.size() != 0); k++) @(negedge aclk);
    if (rq.size() != 0 || bq.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got %0d responses pending, required 0", nm, rq.size() + bq.size());
      rq.delete(); bq.delete();
    end
  endtask

  // last_at: beat index carrying wlast (> len means wlast is never asserted).
  task automatic do_write(input logic [3:0] id, input logic [3:0] wid_v, input logic [31:0] addr,
      input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst, input logic [1:0] lock,
      input logic [3:0] strb, input int last_at, input logic [1:0] exp_resp);
    @(posedge aclk); #1;
    bq.push_back({id, exp_resp});
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awlock = lock;
    awvalid = 1'b1;
    hs_wait(0, "aw_handshake");
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wid = wid_v; wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at);
      hs_wait(1, "w_handshake");
      if (i == last_at) break;
    end
    wvalid = 1'b0; wlast = 1'b0;
    drain("b_drain");
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
      input logic [2:0] size, input logic [1:0] burst, input logic [1:0] lock, input logic [1:0] exp_resp);
    @(posedge aclk); #1;
    for (int i = 0; i <= int'(len); i++) rq.push_back({id, rexp[i], exp_resp, i == int'(len)});
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arlock = lock;
    arvalid = 1'b1;
    hs_wait(2, "ar_handshake");
    arvalid = 1'b0;
    drain("r_drain");
  endtask

  initial begin
    int cnt;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0;
    awcache = '0; awprot = '0; awvalid = 1'b0; wid = '0; wdata = '0; wstrb = '0;
    wlast = 1'b0; wvalid = 1'b0; bready = 1'b1; arid = '0; araddr = '0; arlen = '0;
    arsize = '0; arburst = '0; arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
    rready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    check("reset_ready{aw,w,ar}", 64'({awready, wready, arready}), 64'd0);
    check("reset_valid{b,r,rlast}", 64'({bvalid, rvalid, rlast}), 64'd0);
    check("reset_resp{b,r}", 64'({bresp, rresp}), 64'd0);
    check("reset_payload{rdata,rid,bid}", 64'({rdata, rid, bid}), 64'd0);
    @(posedge aclk); #1;
    check("idle_ready{aw,ar}", 64'({awready, arready}), 64'b11);

    // INCR write then read back
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    do_write(4'd1, 4'd1, 32'h100, 4'd3, 3'd2, INCR, NORMAL, 4'hF, 3, OKAY);
    rexp[0] = 32'h11; rexp[1] = 32'h22; rexp[2] = 32'h33; rexp[3] = 32'h44;
    do_read(4'd1, 32'h100, 4'd3, 3'd2, INCR, NORMAL, OKAY);

    // WRAP write at 0x108 lands at 108,10C,100,104
    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
    do_write(4'd2, 4'd2, 32'h108, 4'd3, 3'd2, WRAP, NORMAL, 4'hF, 3, OKAY);
    rexp[0] = 32'hA2; rexp[1] = 32'hA3; rexp[2] = 32'hA0; rexp[3] = 32'hA1;
    do_read(4'd3, 32'h100, 4'd3, 3'd2, INCR, NORMAL, OKAY);
    rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
    do_read(4'd4, 32'h108, 4'd3, 3'd2, WRAP, NORMAL, OKAY);

    // FIXED write: only the last beat survives at 0x108
    wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2; wbuf[3] = 32'hB3;
    do_write(4'd5, 4'd5, 32'h108, 4'd3, 3'd2, FIXED, NORMAL, 4'hF, 3, OKAY);
    rexp[0] = 32'hA2; rexp[1] = 32'hA3; rexp[2] = 32'hB3; rexp[3] = 32'hA1;
    do_read(4'd5, 32'h100, 4'd3, 3'd2, INCR, NORMAL, OKAY);

    // Byte strobes, then rready held low for five cycles
    wbuf[0] = 32'h11223344;
    do_write(4'd6, 4'd6, 32'h200, 4'd0, 3'd2, INCR, NORMAL, 4'hF, 0, OKAY);
    wbuf[0] = 32'hAABBCCDD;
    do_write(4'd6, 4'd6, 32'h200, 4'd0, 3'd2, INCR, NORMAL, 4'h3, 0, OKAY);
    @(posedge aclk); #1;
    rready = 1'b0;
    rq.push_back({4'd7, 32'h1122CCDD, OKAY, 1'b1});
    arid = 4'd7; araddr = 32'h200; arlen = 4'd0; arsize = 3'd2; arburst = INCR; arlock = NORMAL;
    arvalid = 1'b1;
    hs_wait(2, "ar_handshake_hold");
    arvalid = 1'b0;
    repeat (5) begin
      @(negedge aclk);
      check("hold_rvalid", 64'(rvalid), 64'd1);
      check("hold_rdata", 64'(rdata), 64'h1122CCDD);
    end
    @(posedge aclk); #1;
    rready = 1'b1;
    drain("r_drain_hold");

    // DECERR at the byte span, SLVERR on oversize beat
    rexp[0] = '0; rexp[1] = '0;
    do_read(4'd8, 32'h1000, 4'd1, 3'd2, INCR, NORMAL, DECERR);
    wbuf[0] = 32'hDEADBEEF;
    do_write(4'd8, 4'd8, 32'h1000, 4'd0, 3'd2, INCR, NORMAL, 4'hF, 0, DECERR);
    do_write(4'd9, 4'd9, 32'h100, 4'd0, 3'd3, INCR, NORMAL, 4'hF, 0, SLVERR);
    rexp[0] = 32'hA2;
    do_read(4'd9, 32'h100, 4'd0, 3'd2, INCR, NORMAL, OKAY);

    // Protocol violations: early wlast, wid mismatch, missing wlast, bad WRAP length
    wbuf[0] = 32'h66; wbuf[1] = 32'h77;
    do_write(4'd10, 4'd10, 32'h300, 4'd1, 3'd2, INCR, NORMAL, 4'hF, 1, OKAY);
    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1;
    do_write(4'd11, 4'd11, 32'h300, 4'd3, 3'd2, INCR, NORMAL, 4'hF, 1, SLVERR);
    wbuf[0] = 32'hE0;
    do_write(4'd5, 4'd6, 32'h300, 4'd0, 3'd2, INCR, NORMAL, 4'hF, 0, SLVERR);
    wbuf[0] = 32'hF0;
    do_write(4'd12, 4'd12, 32'h304, 4'd0, 3'd2, INCR, NORMAL, 4'hF, 5, SLVERR);
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3;
    do_write(4'd13, 4'd13, 32'h300, 4'd2, 3'd2, WRAP, NORMAL, 4'hF, 2, SLVERR);
    rexp[0] = 32'hC0; rexp[1] = 32'h77;
    do_read(4'd13, 32'h300, 4'd1, 3'd2, INCR, NORMAL, OKAY);

    // Exclusive access sequence
    wbuf[0] = 32'h40404040;
    do_write(4'd1, 4'd1, 32'h40, 4'd0, 3'd2, INCR, NORMAL, 4'hF, 0, OKAY);
    rexp[0] = 32'h40404040;
    do_read(4'd2, 32'h40, 4'd0, 3'd2, INCR, EXCL, EXP_EX);
    wbuf[0] = 32'h1;
    do_write(4'd2, 4'd2, 32'h40, 4'd0, 3'd2, INCR, EXCL, 4'hF, 0, EXP_EX);
    wbuf[0] = 32'h2;
    do_write(4'd2, 4'd2, 32'h40, 4'd0, 3'd2, INCR, EXCL, 4'hF, 0, OKAY);
    rexp[0] = EXCL_ON ? 32'h1 : 32'h2;
    do_read(4'd2, 32'h40, 4'd0, 3'd2, INCR, NORMAL, OKAY);

    // Reset while beat 2 of an eight-beat read is on the bus
    @(posedge aclk); #1;
    r_mon_en = 1'b0;
    arid = 4'd14; araddr = 32'h100; arlen = 4'd7; arsize = 3'd2; arburst = INCR; arlock = NORMAL;
    arvalid = 1'b1;
    hs_wait(2, "ar_handshake_rst");
    arvalid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 3; k++) begin
      @(negedge aclk);
      if (rvalid && rready) cnt++;
    end
    check("rst_beats_seen", 64'(cnt), 64'd3);
    areset = 1'b1;
    @(posedge aclk); #1;
    check("rst_rvalid_rlast", 64'({rvalid, rlast}), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    areset = 1'b0;
    r_mon_en = 1'b1;
    rexp[0] = 32'hA2;
    do_read(4'd15, 32'h100, 4'd0, 3'd2, INCR, NORMAL, OKAY);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
